mask_pattern_seq: RTL and testbench

- Parametrised successor to the per-subframe mask pattern generator.
- Produces MASK_W-bit mask words for the imager's MSTREAM pattern FIFO in the CLK_HS domain.
- Adds selectable pattern modes, a programmable mask-change period and word count per subframe, and single-shot or continuous frame operation.
- Sits between the host wire-ins (resynchronised upstream) and the pattern FIFO write port.

---
 rtl/mask_seq_pkg.sv | 26 ++
 rtl/mask_pat_next.sv | 36 +++
 rtl/mask_pattern_seq.sv | 163 ++++++++++++++++
 tb/tb_mask_pattern_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_seq_pkg.sv
// Shared encodings and small helpers for the mask pattern sequencer.
package mask_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_ALTINV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_e;

    function automatic logic [31:0] clamp1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

    function automatic logic [31:0] clamp_idx(input logic [31:0] idx, input logic [31:0] max_idx);
        return (idx > max_idx) ? max_idx : idx;
    endfunction

endpackage

// File: rtl/mask_pat_next.sv
// Combinational pattern advance: given the current mask word and mode, produce the next one.
module mask_pat_next
    import mask_seq_pkg::*;
#(
    parameter int MASK_W = 10,
    parameter int IDX_W  = 4
) (
    input  logic [1:0]        mode,
    input  logic [MASK_W-1:0] cur_pat,
    input  logic [IDX_W-1:0]  start,
    input  logic [IDX_W-1:0]  stop,
    output logic [MASK_W-1:0] next_pat
);

    logic [IDX_W-1:0]  start_c;
    logic [IDX_W-1:0]  stop_c;
    logic [MASK_W-1:0] start_hot;

    assign start_c   = IDX_W'(clamp_idx(32'(start), 32'(MASK_W - 1)));
    assign stop_c    = IDX_W'(clamp_idx(32'(stop), 32'(MASK_W - 1)));
    assign start_hot = MASK_W'(1) << start_c;

    always_comb begin
        next_pat = cur_pat;
        case (mode_e'(mode))
            MODE_STATIC: next_pat = cur_pat;
            // Empty or inverted window pins the bit at start.
            MODE_WALK:   next_pat = (start_c >= stop_c || cur_pat[stop_c]) ? start_hot
                                                                          : (cur_pat << 1);
            MODE_COUNT:  next_pat = cur_pat + MASK_W'(1);
            MODE_ALTINV: next_pat = ~cur_pat;
            default:     next_pat = cur_pat;
        endcase
    end

endmodule

// File: rtl/mask_pattern_seq.sv
// Mask pattern sequencer: emits per-subframe mask words into the MSTREAM pattern FIFO.
module mask_pattern_seq
    import mask_seq_pkg::*;
#(
    parameter int MASK_W = 10,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              continuous,
    input  logic [1:0]        mode,
    input  logic [MASK_W-1:0] pat_in,
    input  logic [IDX_W-1:0]  pat_start,
    input  logic [IDX_W-1:0]  pat_stop,
    input  logic [CNT_W-1:0]  num_subc,
    input  logic [CNT_W-1:0]  words_per_subc,
    input  logic [CNT_W-1:0]  chg_period,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [MASK_W-1:0] pat_out,
    output logic [CNT_W-1:0]  subc_cnt,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q;
    mode_e             mode_q;
    logic [IDX_W-1:0]  start_q;
    logic [IDX_W-1:0]  stop_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  period_cnt_q;
    logic [CNT_W-1:0]  subc_cnt_q;
    logic [MASK_W-1:0] cur_pat_q;
    logic [MASK_W-1:0] pat_out_q;
    logic              fifo_wr_q;
    logic              busy_q;
    logic              frame_done_q;

    logic [MASK_W-1:0] next_pat;
    logic [MASK_W-1:0] seed_pat;
    logic [IDX_W-1:0]  start_c;
    logic              last_word;
    logic              last_subc;
    logic              period_hit;

    assign start_c    = IDX_W'(clamp_idx(32'(pat_start), 32'(MASK_W - 1)));
    assign seed_pat   = (mode_e'(mode) == MODE_WALK) ? (MASK_W'(1) << start_c) : pat_in;
    assign last_word  = (word_cnt_q == words_q - CNT_ONE);
    assign last_subc  = (subc_cnt_q == num_q - CNT_ONE);
    assign period_hit = (period_cnt_q + CNT_ONE == period_q);

    mask_pat_next #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W)
    ) u_next (
        .mode     (mode_q),
        .cur_pat  (cur_pat_q),
        .start    (start_q),
        .stop     (stop_q),
        .next_pat (next_pat)
    );

    // Writes are registered: a word issued at an EMIT edge is visible the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_STATIC;
            start_q      <= '0;
            stop_q       <= '0;
            num_q        <= '0;
            words_q      <= '0;
            period_q     <= '0;
            word_cnt_q   <= '0;
            period_cnt_q <= '0;
            subc_cnt_q   <= '0;
            cur_pat_q    <= '0;
            pat_out_q    <= '0;
            fifo_wr_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fifo_wr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        mode_q       <= mode_e'(mode);
                        start_q      <= pat_start;
                        stop_q       <= pat_stop;
                        num_q        <= CNT_W'(clamp1(32'(num_subc)));
                        words_q      <= CNT_W'(clamp1(32'(words_per_subc)));
                        period_q     <= CNT_W'(clamp1(32'(chg_period)));
                        cur_pat_q    <= seed_pat;
                        word_cnt_q   <= '0;
                        period_cnt_q <= '0;
                        subc_cnt_q   <= '0;
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!fifo_full) begin
                        fifo_wr_q <= 1'b1;
                        pat_out_q <= cur_pat_q;
                        if (last_word) begin
                            word_cnt_q <= '0;
                            subc_cnt_q <= subc_cnt_q + CNT_ONE;
                            if (period_hit) begin
                                period_cnt_q <= '0;
                                cur_pat_q    <= next_pat;
                            end else begin
                                period_cnt_q <= period_cnt_q + CNT_ONE;
                            end
                            if (last_subc) begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b1;
                    if (continuous && enable) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign pat_out    = pat_out_q;
    assign subc_cnt   = subc_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mask_pattern_seq.sv
// Scoreboard bench for mask_pattern_seq: expected words are queued at stimulus time and popped on fifo_wr.
module tb_mask_pattern_seq;

    localparam int MASK_W = 10;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              continuous = 1'b0;
    logic [1:0]        mode = '0;
    logic [MASK_W-1:0] pat_in = '0;
    logic [IDX_W-1:0]  pat_start = '0;
    logic [IDX_W-1:0]  pat_stop = '0;
    logic [CNT_W-1:0]  num_subc = '0;
    logic [CNT_W-1:0]  words_per_subc = '0;
    logic [CNT_W-1:0]  chg_period = '0;
    logic              fifo_full = 1'b0;
    logic              fifo_wr;
    logic [MASK_W-1:0] pat_out;
    logic [CNT_W-1:0]  subc_cnt;
    logic              busy;
    logic              frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int last_wr_cyc = 0;
    int first_wr_cyc = -1;
    int last_done_cyc = 0;
    logic [MASK_W-1:0] exp_q[$];

    mask_pattern_seq #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .continuous     (continuous),
        .mode           (mode),
        .pat_in         (pat_in),
        .pat_start      (pat_start),
        .pat_stop       (pat_stop),
        .num_subc       (num_subc),
        .words_per_subc (words_per_subc),
        .chg_period     (chg_period),
        .fifo_full      (fifo_full),
        .fifo_wr        (fifo_wr),
        .pat_out        (pat_out),
        .subc_cnt       (subc_cnt),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pattern seen during a subframe after 'adv' completed change periods.
    function automatic logic [MASK_W-1:0] model_pat(input int m, input int seed, input int st,
                                                    input int sp, input int adv);
        int a;
        int b;
        a = (st > MASK_W - 1) ? MASK_W - 1 : st;
        b = (sp > MASK_W - 1) ? MASK_W - 1 : sp;
        case (m)
            1:       return (a >= b) ? MASK_W'(1 << a) : MASK_W'(1 << (a + adv % (b - a + 1)));
            2:       return MASK_W'(seed + adv);
            3:       return (adv % 2 == 1) ? MASK_W'(~seed) : MASK_W'(seed);
            default: return MASK_W'(seed);
        endcase
    endfunction

    task automatic push_model(input int m, input int seed, input int st, input int sp,
                              input int n, input int w, input int p);
        int nc = (n == 0) ? 1 : n;
        int wc = (w == 0) ? 1 : w;
        int pc = (p == 0) ? 1 : p;
        for (int s = 0; s < nc; s++)
            for (int k = 0; k < wc; k++)
                exp_q.push_back(model_pat(m, seed, st, sp, s / pc));
    endtask

    // Monitor: sample one time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (fifo_wr) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                check("wr_while_full", fifo_full, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got pat_out 0x%0h, expected no write", pat_out);
                end else begin
                    check("pat_out", pat_out, exp_q.pop_front());
                end
            end
            if (frame_done) begin
                done_count++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic run_frame(input int m, input int seed, input int st, input int sp,
                             input int n, input int w, input int p,
                             input int stall_at, input int stall_len, input bit scramble);
        int nc = (n == 0) ? 1 : n;
        int wc = (w == 0) ? 1 : w;
        int total = nc * wc;
        int c_en;
        int base_done;
        int base_wr;
        @(negedge clk);
        mode           = 2'(m);
        pat_in         = MASK_W'(seed);
        pat_start      = IDX_W'(st);
        pat_stop       = IDX_W'(sp);
        num_subc       = CNT_W'(n);
        words_per_subc = CNT_W'(w);
        chg_period     = CNT_W'(p);
        continuous     = 1'b0;
        fifo_full      = 1'b0;
        enable         = 1'b1;
        c_en           = cyc;
        first_wr_cyc   = -1;
        base_done      = done_count;
        base_wr        = wr_count;
        for (int k = 1; k <= total + stall_len + 40 && done_count == base_done; k++) begin
            @(negedge clk);
            fifo_full = (k >= stall_at && k < stall_at + stall_len);
            if (scramble && k >= 2) begin
                mode           = 2'($urandom_range(0, 3));
                pat_in         = MASK_W'($urandom);
                pat_start      = IDX_W'($urandom_range(0, 15));
                pat_stop       = IDX_W'($urandom_range(0, 15));
                num_subc       = CNT_W'($urandom_range(0, 7));
                words_per_subc = CNT_W'($urandom_range(0, 4));
                chg_period     = CNT_W'($urandom_range(0, 4));
            end
        end
        enable    = 1'b0;
        fifo_full = 1'b0;
        check("frame_done_count", done_count - base_done, 1);
        // enable is sampled at the next edge; the first word is visible two edges later
        check("first_wr_latency", first_wr_cyc, c_en + 3);
        check("done_cycle", last_done_cyc, c_en + 3 + total + stall_len);
        check("done_after_last_wr", last_wr_cyc, last_done_cyc - 1);
        check("write_count", wr_count - base_wr, total);
        check("subc_cnt_final", subc_cnt, nc);
        check("busy_after_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int base_wr;
        int base_done;
        int prev_done;
        int m, seed, st, sp, n, w, p, total, s_at, s_len;
        logic [MASK_W-1:0] np;

        repeat (3) @(negedge clk);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_pat_out", pat_out, 0);
        check("rst_subc_cnt", subc_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;

        // STATIC: six identical words
        repeat (6) exp_q.push_back(10'h2A5);
        run_frame(0, 'h2A5, 0, 0, 3, 2, 1, 0, 0, 1'b0);

        // WALK over bits 2..4
        exp_q.push_back(10'h004); exp_q.push_back(10'h008); exp_q.push_back(10'h010);
        exp_q.push_back(10'h004); exp_q.push_back(10'h008);
        run_frame(1, 0, 2, 4, 5, 1, 1, 0, 0, 1'b0);

        // COUNT with period 2, short and extended frames
        exp_q.push_back(10'h3FE); exp_q.push_back(10'h3FE);
        exp_q.push_back(10'h3FF); exp_q.push_back(10'h3FF);
        run_frame(2, 'h3FE, 0, 0, 4, 1, 2, 0, 0, 1'b0);
        exp_q.push_back(10'h3FE); exp_q.push_back(10'h3FE);
        exp_q.push_back(10'h3FF); exp_q.push_back(10'h3FF);
        exp_q.push_back(10'h000); exp_q.push_back(10'h000);
        run_frame(2, 'h3FE, 0, 0, 6, 1, 2, 0, 0, 1'b0);

        // Backpressure: five stalled edges mid-frame, config scrambled while busy
        for (int i = 0; i < 8; i++) exp_q.push_back(MASK_W'(10'h100 + i / 2));
        run_frame(2, 'h100, 0, 0, 4, 2, 1, 4, 5, 1'b1);

        // Randomised frames against the model
        for (int f = 0; f < 12; f++) begin
            m     = $urandom_range(0, 3);
            seed  = $urandom;
            st    = $urandom_range(0, 15);
            sp    = $urandom_range(0, 15);
            n     = $urandom_range(0, 6);
            w     = $urandom_range(0, 3);
            p     = $urandom_range(0, 3);
            total = ((n == 0) ? 1 : n) * ((w == 0) ? 1 : w);
            s_at  = 0;
            s_len = 0;
            if (total >= 3) begin
                s_at  = $urandom_range(3, total + 1);
                s_len = $urandom_range(1, 5);
            end
            push_model(m, seed, st, sp, n, w, p);
            run_frame(m, seed, st, sp, n, w, p, s_at, s_len, 1'b1);
        end

        // Abort after three of six writes
        @(negedge clk);
        mode = 2'd2; pat_in = 10'h055; num_subc = 16'd6; words_per_subc = 16'd1; chg_period = 16'd1;
        exp_q.push_back(10'h055); exp_q.push_back(10'h056); exp_q.push_back(10'h057);
        base_wr = wr_count;
        base_done = done_count;
        enable = 1'b1;
        for (int t = 0; t < 30 && wr_count - base_wr < 3; t++) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_fifo_wr", fifo_wr, 0);
        repeat (5) @(negedge clk);
        check("abort_write_count", wr_count - base_wr, 3);
        check("abort_no_done", done_count - base_done, 0);
        check("abort_queue_drained", exp_q.size(), 0);
        exp_q.delete();

        // Asynchronous reset mid-EMIT
        pat_in = 10'h1C3;
        exp_q.push_back(10'h1C3); exp_q.push_back(10'h1C4);
        base_wr = wr_count;
        enable = 1'b1;
        for (int t = 0; t < 30 && wr_count - base_wr < 2; t++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fifo_wr", fifo_wr, 0);
        check("async_rst_pat_out", pat_out, 0);
        check("async_rst_subc_cnt", subc_cnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_frame_done", frame_done, 0);
        enable = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous one-word frames with zero clamps; new seed applied at each LOAD
        @(negedge clk);
        mode = 2'd3; pat_in = 10'h00F; pat_start = '0; pat_stop = '0;
        num_subc = '0; words_per_subc = '0; chg_period = '0;
        continuous = 1'b1;
        exp_q.push_back(10'h00F);
        base_done = done_count;
        prev_done = -1;
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int t = 0; t < 20 && done_count <= base_done + f; t++) @(negedge clk);
            check("cont_done_count", done_count - base_done, f + 1);
            if (prev_done >= 0) check("cont_done_spacing", last_done_cyc - prev_done, 3);
            prev_done = last_done_cyc;
            if (f < 3) begin
                np = MASK_W'($urandom);
                pat_in = np;
                exp_q.push_back(np);
            end
        end
        enable = 1'b0;
        continuous = 1'b0;
        repeat (4) @(negedge clk);
        check("cont_queue_drained", exp_q.size(), 0);
        check("cont_busy_end", busy, 0);
        check("cont_done_total", done_count - base_done, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
